// File: rtl/uart_tx_if.sv
// uart_tx_if: transmit-data valid/ready handshake between a producer and uart_tx
interface uart_tx_if #(
    parameter int DATA_BITS = 8
);
    logic [DATA_BITS-1:0] tx_data;
    logic                 tx_valid;
    logic                 tx_ready;
    modport master (output tx_data, output tx_valid, input tx_ready);
    modport slave  (input tx_data, input tx_valid, output tx_ready);
endinterface

// File: rtl/uart_tx.sv
// uart_tx: double-buffered UART transmitter with optional parity and one or two stop bits
module uart_tx #(
    parameter int DATA_BITS = 8,
    parameter int PARITY    = 0,
    parameter int STOP_BITS = 1
) (
    input  logic     clk,
    input  logic     rst,
    input  logic     baud16x_tick,
    uart_tx_if.slave bus,
    output logic     tx,
    output logic     busy,
    output logic     done
);
    localparam int BW = $clog2(DATA_BITS);
    localparam logic [BW-1:0] LAST_BIT = BW'(DATA_BITS - 1);
    typedef enum logic [2:0] {S_IDLE, S_START, S_DATA, S_PARITY, S_STOP} state_t;
    state_t               state, state_n;
    logic [DATA_BITS-1:0] shift, shift_n;
    logic [DATA_BITS-1:0] hold, hold_n;
    logic                 hold_full, hold_full_n;
    logic                 par_bit, par_n;
    logic [3:0]           tick_cnt, tick_n;
    logic [BW-1:0]        bit_cnt, bit_n;
    logic                 stop_cnt, stop_n;
    logic                 tx_n, done_n;
    logic                 bit_end, load;
    assign bus.tx_ready = !hold_full;
    assign busy = (state != S_IDLE) || hold_full;
    // next-state, datapath and registered-output computation
    always_comb begin
        state_n     = state;
        shift_n     = shift;
        hold_n      = hold;
        hold_full_n = hold_full;
        par_n       = par_bit;
        tick_n      = tick_cnt;
        bit_n       = bit_cnt;
        stop_n      = stop_cnt;
        done_n      = 1'b0;
        load        = 1'b0;
        bit_end     = (state != S_IDLE) && baud16x_tick && (tick_cnt == 4'd15);
        if ((state != S_IDLE) && baud16x_tick) tick_n = tick_cnt + 4'd1;
        case (state)
            S_IDLE:   load = hold_full;
            S_START:  if (bit_end) begin
                          state_n = S_DATA;
                          bit_n   = '0;
                      end
            S_DATA:   if (bit_end) begin
                          shift_n = shift >> 1;
                          bit_n   = bit_cnt + 1'b1;
                          if (bit_cnt == LAST_BIT) begin
                              bit_n   = '0;
                              stop_n  = 1'b0;
                              state_n = (PARITY != 0) ? S_PARITY : S_STOP;
                          end
                      end
            S_PARITY: if (bit_end) begin
                          state_n = S_STOP;
                          stop_n  = 1'b0;
                      end
            S_STOP:   if (bit_end) begin
                          if (STOP_BITS == 2 && !stop_cnt) stop_n = 1'b1;
                          else begin
                              done_n  = 1'b1;
                              state_n = S_IDLE;
                              load    = hold_full;
                          end
                      end
            default:  state_n = S_IDLE;
        endcase
        if (load) begin
            shift_n     = hold;
            par_n       = (^hold) ^ (PARITY == 2);
            hold_full_n = 1'b0;
            state_n     = S_START;
            tick_n      = '0;
            bit_n       = '0;
            stop_n      = 1'b0;
        end
        if (bus.tx_valid && !hold_full) begin
            hold_n      = bus.tx_data;
            hold_full_n = 1'b1;
        end
        tx_n = (state_n == S_START)  ? 1'b0 :
               (state_n == S_DATA)   ? shift_n[0] :
               (state_n == S_PARITY) ? par_n : 1'b1;
    end
    // state and datapath registers; reset aborts any frame and drops held data
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state     <= S_IDLE;
            shift     <= '0;
            hold      <= '0;
            hold_full <= 1'b0;
            par_bit   <= 1'b0;
            tick_cnt  <= '0;
            bit_cnt   <= '0;
            stop_cnt  <= 1'b0;
            tx        <= 1'b1;
            done      <= 1'b0;
        end else begin
            state     <= state_n;
            shift     <= shift_n;
            hold      <= hold_n;
            hold_full <= hold_full_n;
            par_bit   <= par_n;
            tick_cnt  <= tick_n;
            bit_cnt   <= bit_n;
            stop_cnt  <= stop_n;
            tx        <= tx_n;
            done      <= done_n;
        end
    end
endmodule

// File: tb/tb_uart_tx.sv
// tb_uart_tx: directed self-checking bench for uart_tx across four parameter sets
module tb_uart_tx;
    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       tick = 1'b0;
    logic       tick_en = 1'b1;
    logic [1:0] div = '0;
    int         cyc = 0;
    int         n_cmp = 0;
    int         n_err = 0;
    int         dcnt0 = 0;
    int         d_last = 0;
    int         d_prev = 0;
    int         c0;
    int         bad;
    logic [3:0] tx_v, busy_v, done_v, rdy_v;

    uart_tx_if #(.DATA_BITS(8)) i0 ();
    uart_tx_if #(.DATA_BITS(8)) i1 ();
    uart_tx_if #(.DATA_BITS(8)) i2 ();
    uart_tx_if #(.DATA_BITS(5)) i3 ();

    uart_tx u0 (.clk(clk), .rst(rst), .baud16x_tick(tick), .bus(i0),
                .tx(tx_v[0]), .busy(busy_v[0]), .done(done_v[0]));
    uart_tx #(.PARITY(1)) u1 (.clk(clk), .rst(rst), .baud16x_tick(tick), .bus(i1),
                .tx(tx_v[1]), .busy(busy_v[1]), .done(done_v[1]));
    uart_tx #(.PARITY(2)) u2 (.clk(clk), .rst(rst), .baud16x_tick(tick), .bus(i2),
                .tx(tx_v[2]), .busy(busy_v[2]), .done(done_v[2]));
    uart_tx #(.DATA_BITS(5), .STOP_BITS(2)) u3 (.clk(clk), .rst(rst), .baud16x_tick(tick), .bus(i3),
                .tx(tx_v[3]), .busy(busy_v[3]), .done(done_v[3]));

    assign rdy_v = {i3.tx_ready, i2.tx_ready, i1.tx_ready, i0.tx_ready};

    always #5 clk = ~clk;

    // baud16x tick every 4 clk; pausing tick_en delays the whole tick train
    always @(posedge clk) begin
        cyc  <= cyc + 1;
        if (tick_en) div <= div + 2'd1;
        tick <= tick_en && (div == 2'd3);
    end

    // done pulse bookkeeping for instance 0
    always @(posedge clk) begin
        if (done_v[0]) begin
            dcnt0  <= dcnt0 + 1;
            d_prev <= d_last;
            d_last <= cyc;
        end
    end

    initial begin
        #2ms;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    task automatic chk1(input string tag, input logic obs, input logic exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %b expected %b", tag, obs, exp);
        end
    endtask

    task automatic chkn(input string tag, input int obs, input int exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic drive(input int idx, input logic v, input logic [7:0] d);
        i0.tx_valid = (idx == 0) && v;
        i1.tx_valid = (idx == 1) && v;
        i2.tx_valid = (idx == 2) && v;
        i3.tx_valid = (idx == 3) && v;
        i0.tx_data = d;
        i1.tx_data = d;
        i2.tx_data = d;
        i3.tx_data = d[4:0];
    endtask

    // aligns acceptance so the load edge coincides with a tick edge; returns at offset 0 of the start bit
    task automatic send(input int idx, input logic [7:0] d, input logic keep);
        bit found = 1'b0;
        for (int i = 0; i < 8 && !found; i++) begin
            @(negedge clk);
            found = tick;
        end
        n_cmp++;
        assert (found) else begin
            n_err++;
            $error("FAIL tick_wait: observed no tick expected a tick within 8 clk");
        end
        repeat (3) @(negedge clk);
        drive(idx, 1'b1, d);
        @(negedge clk);
        chk1("accept_ready", rdy_v[idx], 1'b0);
        chk1("accept_busy", busy_v[idx], 1'b1);
        chk1("accept_tx", tx_v[idx], 1'b1);
        if (!keep) drive(idx, 1'b0, d);
        @(negedge clk);
        chk1("load_ready", rdy_v[idx], 1'b1);
        chk1("load_tx", tx_v[idx], 1'b0);
    endtask

    // checks the first and last clk of every bit, then done at the frame end
    task automatic check_frame(input int idx, input logic [15:0] exp, input int nbits, input int off);
        for (int k = 0; k < nbits; k++) begin
            if (k > 0 || off == 0) chk1("bit_first", tx_v[idx], exp[k]);
            repeat ((k == 0) ? 63 - off : 63) @(negedge clk);
            chk1("bit_last", tx_v[idx], exp[k]);
            @(negedge clk);
        end
        chk1("frame_done", done_v[idx], 1'b1);
    endtask

    initial begin
        drive(0, 1'b0, 8'h00);
        repeat (3) @(negedge clk);
        for (int i = 0; i < 4; i++) begin
            chk1("rst_tx", tx_v[i], 1'b1);
            chk1("rst_busy", busy_v[i], 1'b0);
            chk1("rst_done", done_v[i], 1'b0);
            chk1("rst_ready", rdy_v[i], 1'b1);
        end
        rst = 1'b1;
        repeat (40) @(negedge clk);
        chk1("idle_tx", tx_v[0], 1'b1);
        chk1("idle_busy", busy_v[0], 1'b0);
        c0 = dcnt0;
        send(0, 8'h55, 1'b0);
        check_frame(0, 16'h02AA, 10, 0);
        @(negedge clk);
        chk1("done_pulse", done_v[0], 1'b0);
        chk1("after_busy", busy_v[0], 1'b0);
        chkn("done_count", dcnt0 - c0, 1);
        send(1, 8'h07, 1'b0);
        check_frame(1, 16'h060E, 11, 0);
        @(negedge clk);
        chk1("even_done_pulse", done_v[1], 1'b0);
        send(2, 8'h07, 1'b0);
        check_frame(2, 16'h040E, 11, 0);
        @(negedge clk);
        chk1("odd_done_pulse", done_v[2], 1'b0);
        send(3, 8'h1F, 1'b0);
        check_frame(3, 16'h00FE, 8, 0);
        @(negedge clk);
        chk1("stop2_done_pulse", done_v[3], 1'b0);
        c0 = dcnt0;
        send(0, 8'hA3, 1'b1);
        drive(0, 1'b1, 8'h3C);
        @(negedge clk);
        chk1("b2b_accept", rdy_v[0], 1'b0);
        drive(0, 1'b0, 8'h3C);
        check_frame(0, 16'h0346, 10, 1);
        check_frame(0, 16'h0278, 10, 0);
        @(negedge clk);
        chkn("b2b_done_gap", d_last - d_prev, 640);
        chkn("b2b_done_count", dcnt0 - c0, 2);
        c0 = dcnt0;
        send(0, 8'h55, 1'b0);
        drive(0, 1'b1, 8'hC3);
        @(negedge clk);
        chk1("held_ready", rdy_v[0], 1'b0);
        drive(0, 1'b0, 8'hC3);
        repeat (279) @(negedge clk);
        chk1("pre_rst_tx", tx_v[0], 1'b0);
        rst = 1'b0;
        #1;
        chk1("rst_mid_tx", tx_v[0], 1'b1);
        chk1("rst_mid_busy", busy_v[0], 1'b0);
        chk1("rst_mid_ready", rdy_v[0], 1'b1);
        chk1("rst_mid_done", done_v[0], 1'b0);
        repeat (3) @(negedge clk);
        rst = 1'b1;
        bad = 0;
        for (int i = 0; i < 700; i++) begin
            @(negedge clk);
            if (tx_v[0] !== 1'b1 || busy_v[0] !== 1'b0) bad++;
        end
        chkn("post_rst_quiet", bad, 0);
        chkn("post_rst_no_done", dcnt0 - c0, 0);
        send(0, 8'h81, 1'b0);
        check_frame(0, 16'h0302, 10, 0);
        send(0, 8'h55, 1'b0);
        repeat (212) @(negedge clk);
        chk1("stall_pre", tx_v[0], 1'b1);
        tick_en = 1'b0;
        repeat (100) @(negedge clk);
        chk1("stall_hold", tx_v[0], 1'b1);
        tick_en = 1'b1;
        repeat (43) @(negedge clk);
        chk1("stall_last", tx_v[0], 1'b1);
        @(negedge clk);
        check_frame(0, 16'h002A, 6, 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule

// File: doc/uart_tx.md
UART_TX -- requirements
Module: uart_tx

Interface
REQ-001 Parameter DATA_BITS, default 8, SHALL set the data bits per frame (legal 5..8).
REQ-002 Parameter PARITY, default 0, SHALL select parity: 0 = none, 1 = even, 2 = odd.
REQ-003 Parameter STOP_BITS, default 1, SHALL set the stop bits per frame (legal 1 or 2).
REQ-004 clk  input  1  SHALL be the system clock; all logic is rising-edge clk.
REQ-005 rst  input  1  SHALL be the asynchronous, active-low reset.
REQ-006 baud16x_tick  input  1  SHALL be a one-clk-wide enable pulse at 16x the baud rate, synchronous to clk.
REQ-007 tx_data  input  DATA_BITS  SHALL carry the byte to send, sampled when tx_valid & tx_ready.
REQ-008 tx_valid  input  1  SHALL indicate tx_data is valid.
REQ-009 tx_ready  output  1  SHALL indicate the holding register is empty.
REQ-010 tx  output  1  SHALL be the serial line, idle high.
REQ-011 busy  output  1  SHALL be high whenever the FSM is not IDLE or the holding register is full.
REQ-012 done  output  1  SHALL pulse high for one clk at the end of each frame's last stop bit.

Function
REQ-013 Handshake: the block SHALL accept a transfer on any clk edge where tx_valid & tx_ready, latching tx_data into a one-entry holding register; tx_ready SHALL go low on the next clk.
REQ-014 FSM states SHALL be IDLE, START, DATA, PARITY, STOP.
REQ-015 IDLE with holding register full: on the next clk the block SHALL move the holding data into the shift register, clear the holding register, enter START, and zero the tick counter.
REQ-016 Bit timing: each bit SHALL last exactly 16 baud16x_tick pulses, counted by a 4-bit tick counter; the bit ends on the clk where the 16th tick is counted (counter wraps 15->0).
REQ-017 START SHALL drive tx = 0 for one bit time, then enter DATA.
REQ-018 DATA SHALL drive shift[0] (LSB first), shifting right at each bit end; after DATA_BITS bits it SHALL enter PARITY if PARITY != 0, else STOP.
REQ-019 PARITY SHALL drive the XOR of all data bits for even parity, or its inverse for odd parity, for one bit time.
REQ-020 STOP SHALL drive tx = 1 for STOP_BITS bit times, using a 1-bit stop counter when STOP_BITS = 2.
REQ-021 At the end of the last stop bit the block SHALL assert done; if the holding register is full it SHALL load it and enter START on the same clk (no idle gap), else enter IDLE.
REQ-022 A new transfer SHALL be acceptable while a frame is in progress (double buffering); a transfer accepted on the same clk as the holding-to-shift load SHALL land in the now-empty holding register and SHALL not be lost.
REQ-023 tx SHALL be driven from a register (glitch-free); data changes SHALL occur only at bit boundaries.
REQ-024 tx_data SHALL be ignored when tx_ready is low; stall on tx_valid SHALL not affect the frame in progress.
REQ-025 baud16x_tick pulses arriving while in IDLE SHALL be ignored, and the tick counter SHALL hold 0 in IDLE.

Reset
REQ-026 When rst = 0 the block SHALL asynchronously force: state IDLE, tx = 1, tx_ready = 1, busy = 0, done = 0, holding register empty, shift register 0, tick and bit counters 0.
REQ-027 Reset asserted mid-frame SHALL abort the frame immediately (tx = 1), discard held data, and not assert done.
REQ-028 After reset release the block SHALL accept a transfer on the first clk edge where tx_valid = 1.

Verification
REQ-029 Defaults; tick every 4 clk; send 0x55 -> tx = 0 (start), then 1,0,1,0,1,0,1,0, then 1 (stop), each bit lasting 64 clk; done pulses once after 640 clk; tx_ready is high again 1 clk after acceptance.
REQ-030 PARITY = 1; send 0x07 -> parity bit = 1; PARITY = 2; send 0x07 -> parity bit = 0; frame length is 11 bit times.
REQ-031 Back-to-back: send 0xA3 then 0x3C immediately, tx_valid held high -> second frame's start bit directly follows the first stop bit with no idle gap; two done pulses occur 160 ticks apart.
REQ-032 STOP_BITS = 2, DATA_BITS = 5, send 0x1F -> frame of 8 bit times, last 2 high; bits above DATA_BITS ignored.
REQ-033 Assert rst at tick 70 of a frame -> tx = 1 within the same clk, busy = 0, no done pulse; a new send of 0x81 afterwards produces a correct frame.
REQ-034 Hold baud16x_tick low for 100 clk mid-bit -> tx holds its current bit and the frame resumes correctly when ticks restart.
